// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the regfile write-port arbiter.
// Sequencer state encoding, parameter defaults and requester indices.
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int LEN_W_DEF  = 3;

  localparam int REQ_BURST  = 0;
  localparam int REQ_SINGLE = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin pick (rr_arbiter2): the pointed-to requester wins if it asks,
// otherwise the other one does.
module regfile_write_arbiter_rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o  = |req_i;
  assign winner_o = req_i[ptr_i] ? ptr_i : ~ptr_i;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between two burst requesters, round-robin,
// with zero-bubble hand-off from the last beat of one burst to the next.
//
// state    | meaning
// ST_IDLE  | no owner, outputs quiet, waiting for any request
// ST_BURST | owner_q writes one register per cycle until count_q reaches 0
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [REG_W-1:0]  start_reg0_i,
  input  logic [REG_W-1:0]  start_reg1_i,
  input  logic [LEN_W-1:0]  len0_i,
  input  logic [LEN_W-1:0]  len1_i,
  input  logic              dir0_i,
  input  logic              dir1_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [1:0]        grant_o,
  output logic [1:0]        beat_ack_o,
  output logic [1:0]        done_o,
  output logic              busy_o,
  output logic              wr_enable_o,
  output logic [REG_W-1:0]  wr_regnum_o,
  output logic [DATA_W-1:0] wr_data_o
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [REG_W-1:0]   cursor_q, cursor_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               dir_q, dir_d;
  logic               rr_ptr_q, rr_ptr_d;

  logic               arb_ptr, arb_valid, arb_winner;
  logic               load;
  logic               last_beat;

  assign last_beat = (state_q == ST_BURST) && (count_q == '0);

  // On the last beat the pointer already favours the other requester.
  assign arb_ptr = (state_q == ST_BURST) ? ~owner_q : rr_ptr_q;

  regfile_write_arbiter_rr_arbiter2 u_rr (
    .req_i    (req_i),
    .ptr_i    (arb_ptr),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cursor_d = cursor_q;
    count_d  = count_q;
    dir_d    = dir_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: load = arb_valid;
      ST_BURST: begin
        cursor_d = dir_q ? cursor_q + REG_W'(1) : cursor_q - REG_W'(1);
        count_d  = count_q - LEN_W'(1);
        if (last_beat) begin
          rr_ptr_d = ~owner_q;
          load     = arb_valid;
          if (!arb_valid) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d  = ST_BURST;
      owner_d  = arb_winner;
      cursor_d = arb_winner ? start_reg1_i : start_reg0_i;
      count_d  = arb_winner ? len1_i : len0_i;
      dir_d    = arb_winner ? dir1_i : dir0_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      cursor_q <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cursor_q <= cursor_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // r0 is hardwired in the regfile: the beat is consumed but never written.
  always_comb begin
    grant_o     = '0;
    beat_ack_o  = '0;
    done_o      = '0;
    busy_o      = 1'b0;
    wr_enable_o = 1'b0;
    wr_regnum_o = '0;
    wr_data_o   = '0;
    if (state_q == ST_BURST) begin
      grant_o     = onehot2(owner_q);
      beat_ack_o  = onehot2(owner_q);
      done_o      = (count_q == '0) ? onehot2(owner_q) : 2'b00;
      busy_o      = 1'b1;
      wr_enable_o = (cursor_q != '0);
      wr_regnum_o = cursor_q;
      wr_data_o   = (owner_q == 1'(REQ_SINGLE)) ? data1_i : data0_i;
    end
  end

endmodule
